// File: rtl/sum_accumulator_pipe.sv
// -----------------------------------------------------------------------------
// sum_accumulator_pipe
//   Downstream stage of the combinational width-bit adder. Accepts one
//   (width+1)-bit sum per valid, enabled cycle and adds n_terms of them into a
//   batch total. The total is registered and held. A one-enabled-cycle valid
//   pulse marks it, and a sticky per-batch overflow flag goes with it.
//
// Parameters
//   width     : operand width of the upstream adder (sum is width+1 bits)
//   n_terms   : sums per batch (>= 1)
//   acc_width : accumulator / result width
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous reset, active low
//   clk_en  in   clock enable; all state holds when 0
//   clear   in   synchronous batch abort (qualified by clk_en)
//   sum_vld in   sum valid (no backpressure)
//   sum     in   adder result {carry_out, z}
//   busy    out  batch partially accumulated
//   cnt     out  terms accepted in the current batch
//   res_vld out  result valid pulse
//   res     out  last completed batch total (held)
//   res_ovf out  last batch exceeded acc_width bits (held)
// -----------------------------------------------------------------------------
module sum_accumulator_pipe #(
  parameter int width     = 8,
  parameter int n_terms   = 4,
  parameter int acc_width = width + 1 + $clog2(n_terms)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic                           clear,
  input  logic                           sum_vld,
  input  logic [width:0]                 sum,
  output logic                           busy,
  output logic [$clog2(n_terms+1)-1:0]   cnt,
  output logic                           res_vld,
  output logic [acc_width-1:0]           res,
  output logic                           res_ovf
);

  localparam int CNT_W = $clog2(n_terms + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]           r_state;
  logic [acc_width-1:0] r_acc;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_res_vld;
  logic [acc_width-1:0] r_res;
  logic                 r_res_ovf;

  logic [acc_width-1:0] w_base_acc;
  logic                 w_base_ovf;
  logic [CNT_W-1:0]     w_base_cnt;
  logic [acc_width:0]   w_add;
  logic [acc_width-1:0] w_acc_next;
  logic                 w_ovf_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_done;

  // An IDLE accept is the same add as an ACCUM accept with the running
  // state forced to zero, so one adder serves both states. The carry from
  // 0 + sum is always 0, which leaves ovf cleared at the start of a batch.
  always_comb begin
    // NOTE: every combinational output is assigned first so no path can infer a latch.
    w_base_acc = '0;
    w_base_ovf = 1'b0;
    w_base_cnt = '0;
    if (r_state == ST_ACCUM) begin
      w_base_acc = r_acc;
      w_base_ovf = r_ovf;
      w_base_cnt = r_cnt;
    end
    w_add      = {1'b0, w_base_acc} + (acc_width + 1)'(sum);
    w_acc_next = w_add[acc_width-1:0];
    w_ovf_next = w_base_ovf | w_add[acc_width];
    w_cnt_next = w_base_cnt + CNT_W'(1);
    w_done     = (w_cnt_next == CNT_W'(n_terms));
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_res_vld <= 1'b0;
      r_res     <= '0;
      r_res_ovf <= 1'b0;
    end else if (clk_en) begin
      if (clear) begin
        // Abort: drop the partial batch and any pending pulse. The result stays.
        r_state   <= ST_IDLE;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        r_cnt     <= '0;
        r_res_vld <= 1'b0;
      end else begin
        r_res_vld <= 1'b0;
        if (sum_vld) begin
          r_acc <= w_acc_next;
          r_ovf <= w_ovf_next;
          if (w_done) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_res     <= w_acc_next;
            r_res_ovf <= w_ovf_next;
            r_res_vld <= 1'b1;
          end else begin
            r_state <= ST_ACCUM;
            r_cnt   <= w_cnt_next;
          end
        end
      end
    end
  end

  assign busy    = (r_state == ST_ACCUM);
  assign cnt     = r_cnt;
  assign res_vld = r_res_vld;
  assign res     = r_res;
  assign res_ovf = r_res_ovf;

endmodule
